// File: rtl/lfsr_galois_gen.sv
// Galois LFSR pattern generator: STEP sub-steps per advance, dout/out_valid one cycle after accepted shift_en.
// Backpressure: while out_valid && !out_ready the state, dout and adv_cnt hold and shift_en is ignored.
module lfsr_galois_gen #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = 16'h6801,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1,
  parameter                  DIR   = "MSB",
  parameter int              STEP  = 1,
  parameter int              CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             shift_en,
  input  logic [STEP-1:0]  din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [STEP-1:0]  dout,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  output logic             wrap,
  output logic [CNT_W-1:0] adv_cnt
);

  localparam bit DIR_LSB = (DIR == "LSB");

  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] s_chain;
  logic [WIDTH-1:0] nxt;
  logic [STEP-1:0]  o_bits;
  logic             nxt_zero;
  logic             adv;

  // Chain of single-bit Galois steps; din[i] is injected in sub-step i.
  always_comb begin
    s_chain = state;
    o_bits  = '0;
    for (int i = 0; i < STEP; i++) begin
      o_bits[i] = DIR_LSB ? s_chain[0] : s_chain[WIDTH-1];
      s_chain   = (DIR_LSB ? (s_chain >> 1) : (s_chain << 1))
                ^ ({WIDTH{o_bits[i] ^ din[i]}} & POLY);
    end
  end

  assign nxt_zero = (s_chain == '0);
  assign nxt      = nxt_zero ? SEED : s_chain;
  assign adv      = shift_en && !load && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      seed_reg  <= SEED;
      out_valid <= 1'b0;
      dout      <= '0;
      lockup    <= 1'b0;
      wrap      <= 1'b0;
      adv_cnt   <= '0;
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
      if (load) begin
        // A zero seed would lock the register up, so it is replaced by SEED.
        if (seed_in == '0) begin
          state    <= SEED;
          seed_reg <= SEED;
          lockup   <= 1'b1;
        end else begin
          state    <= seed_in;
          seed_reg <= seed_in;
        end
        out_valid <= 1'b0;
        adv_cnt   <= '0;
      end else if (adv) begin
        state     <= nxt;
        dout      <= o_bits;
        out_valid <= 1'b1;
        lockup    <= nxt_zero;
        wrap      <= (nxt == seed_reg);
        if (adv_cnt != '1)
          adv_cnt <= adv_cnt + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// Directed bench for lfsr_galois_gen: default build plus STEP=4 (MSB) and DIR="LSB" builds
// checked against a single-sub-step reference model.
module tb_lfsr_galois_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] seed_in;
  logic        shift_en;
  logic        din;
  logic        out_ready;
  logic        out_valid;
  logic        dout;
  logic [15:0] state;
  logic        lockup;
  logic        wrap;
  logic [31:0] adv_cnt;

  logic        s4_load;
  logic [15:0] s4_seed;
  logic        s4_en;
  logic [3:0]  s4_din;
  logic        s4_rdy;
  logic        s4_vld;
  logic [3:0]  s4_dout;
  logic [15:0] s4_state;
  logic        s4_lock;
  logic        s4_wrap;
  logic [3:0]  s4_cnt;

  logic        lb_load;
  logic [15:0] lb_seed;
  logic        lb_en;
  logic        lb_din;
  logic        lb_rdy;
  logic        lb_vld;
  logic        lb_dout;
  logic [15:0] lb_state;
  logic        lb_lock;
  logic        lb_wrap;
  logic [31:0] lb_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_galois_gen u_dut (
    .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .shift_en(shift_en), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .state(state),
    .lockup(lockup), .wrap(wrap), .adv_cnt(adv_cnt)
  );

  lfsr_galois_gen #(.STEP(4), .CNT_W(4)) u_s4 (
    .clk(clk), .rst(rst), .load(s4_load), .seed_in(s4_seed), .shift_en(s4_en), .din(s4_din),
    .out_valid(s4_vld), .out_ready(s4_rdy), .dout(s4_dout), .state(s4_state),
    .lockup(s4_lock), .wrap(s4_wrap), .adv_cnt(s4_cnt)
  );

  lfsr_galois_gen #(.DIR("LSB"), .POLY(16'hB400)) u_lsb (
    .clk(clk), .rst(rst), .load(lb_load), .seed_in(lb_seed), .shift_en(lb_en), .din(lb_din),
    .out_valid(lb_vld), .out_ready(lb_rdy), .dout(lb_dout), .state(lb_state),
    .lockup(lb_lock), .wrap(lb_wrap), .adv_cnt(lb_cnt)
  );

  // Reference single sub-step: returns {out_bit, next_state}.
  function automatic logic [16:0] sub_step(input logic [15:0] s, input logic d,
                                           input bit lsb, input logic [15:0] poly);
    logic        o;
    logic [15:0] n;
    o = lsb ? s[0] : s[15];
    n = lsb ? {1'b0, s[15:1]} : {s[14:0], 1'b0};
    if (o ^ d) n = n ^ poly;
    return {o, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 0; seed_in = 0; shift_en = 0; din = 0; out_ready = 0;
    #12 rst = 1'b0;
    #1;
    checks++; if (state !== 16'hACE1) begin errors++; $display("FAIL reset_state got %h want ace1", state); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (adv_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", adv_cnt); end
    checks++; if ({dout, lockup, wrap} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {dout, lockup, wrap}); end
    shift_en = 1; out_ready = 1;
    tick(); tick(); tick();
    checks++; if (adv_cnt !== 32'd3) begin errors++; $display("FAIL run_cnt got %0d want 3", adv_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL run_valid got %b want 1", out_valid); end
    #3 rst = 1'b1;
    #1;
    checks++; if (state !== 16'hACE1) begin errors++; $display("FAIL midrst_state got %h want ace1", state); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (adv_cnt !== 32'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", adv_cnt); end
    shift_en = 0;
    #2 rst = 1'b0;
    tick();
    checks++; if (state !== 16'hACE1) begin errors++; $display("FAIL post_rst_state got %h want ace1", state); end
  endtask

  task automatic test_sequence();
    logic [15:0] exp;
    load = 1; seed_in = 16'h0001; shift_en = 0; din = 0; out_ready = 1;
    tick();
    load = 0;
    checks++; if (state !== 16'h0001 || out_valid !== 1'b0 || adv_cnt !== 32'd0) begin
      errors++; $display("FAIL seq_load got %h/%b/%0d want 0001/0/0", state, out_valid, adv_cnt);
    end
    shift_en = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i < 16) ? (16'h0001 << i) : 16'h6801;
      checks++; if (state !== exp) begin errors++; $display("FAIL seq_state[%0d] got %h want %h", i, state, exp); end
      checks++; if (dout !== (i == 16)) begin errors++; $display("FAIL seq_dout[%0d] got %b want %b", i, dout, (i == 16)); end
      checks++; if (out_valid !== 1'b1 || adv_cnt !== 32'(i) || wrap !== 1'b0) begin
        errors++; $display("FAIL seq_ctl[%0d] got %b/%0d/%b want 1/%0d/0", i, out_valid, adv_cnt, wrap, i);
      end
    end
    shift_en = 0;
    tick();
  endtask

  task automatic test_period();
    int wraps = 0;
    int widx  = 0;
    load = 1; seed_in = 16'h0001; din = 0; out_ready = 1; shift_en = 0;
    tick();
    load = 0; shift_en = 1;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      if (wrap === 1'b1) begin wraps++; widx = k; end
    end
    shift_en = 0;
    checks++; if (wraps !== 1 || widx !== 65535) begin errors++; $display("FAIL period_wrap got %0d pulses at %0d want 1 at 65535", wraps, widx); end
    checks++; if (adv_cnt !== 32'd65535) begin errors++; $display("FAIL period_cnt got %0d want 65535", adv_cnt); end
    checks++; if (state !== 16'h0001) begin errors++; $display("FAIL period_state got %h want 0001", state); end
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL period_wrap_clr got %b want 0", wrap); end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat = 16'hA5C3;
    logic [15:0] ms;
    logic        mv, md, madv;
    int          mcnt;
    logic [16:0] r;
    logic [15:0] snap_s;
    logic        snap_d;
    logic [31:0] snap_c;
    logic        got[$];
    logic        exp[$];
    load = 1; seed_in = 16'h1234; shift_en = 0; din = 0; out_ready = 1;
    tick();
    load = 0;
    ms = 16'h1234; mv = 0; md = 0; mcnt = 0;
    for (int c = 0; c < 15; c++) begin
      shift_en  = (c < 14);
      out_ready = !(c >= 3 && c <= 7);
      din       = pat[c];
      if (c == 3) begin snap_s = state; snap_d = dout; snap_c = adv_cnt; end
      if (out_valid && out_ready) got.push_back(dout);
      if (mv && out_ready) exp.push_back(md);
      madv = shift_en && (!mv || out_ready);
      if (madv) begin
        r = sub_step(ms, din, 0, 16'h6801);
        md = r[16]; ms = (r[15:0] == 16'h0) ? 16'hACE1 : r[15:0]; mv = 1; mcnt++;
      end else if (mv && out_ready) begin
        mv = 0;
      end
      tick();
      checks++; if (state !== ms || dout !== md || out_valid !== mv || adv_cnt !== 32'(mcnt)) begin
        errors++; $display("FAIL bp_cycle[%0d] got %h/%b/%b/%0d want %h/%b/%b/%0d", c, state, dout, out_valid, adv_cnt, ms, md, mv, mcnt);
      end
      if (c >= 3 && c <= 7) begin
        checks++; if (state !== snap_s || dout !== snap_d || adv_cnt !== snap_c) begin
          errors++; $display("FAIL bp_stall[%0d] got %h/%b/%0d want %h/%b/%0d", c, state, dout, adv_cnt, snap_s, snap_d, snap_c);
        end
      end
    end
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_bit[%0d] got %b want %b", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_lockup();
    shift_en = 0; din = 0; out_ready = 1;
    load = 1; seed_in = 16'h0000;
    tick();
    load = 0;
    checks++; if (state !== 16'hACE1 || lockup !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lock_load got %h/%b/%b want ace1/1/0", state, lockup, out_valid);
    end
    tick();
    checks++; if (lockup !== 1'b0 || state !== 16'hACE1) begin errors++; $display("FAIL lock_pulse got %b/%h want 0/ace1", lockup, state); end
    load = 1; seed_in = 16'h8000;
    tick();
    load = 0; shift_en = 1; din = 1;
    tick();
    shift_en = 0; din = 0;
    checks++; if (state !== 16'hACE1 || lockup !== 1'b1) begin errors++; $display("FAIL lock_din got %h/%b want ace1/1", state, lockup); end
    checks++; if (dout !== 1'b1 || out_valid !== 1'b1 || adv_cnt !== 32'd1 || wrap !== 1'b0) begin
      errors++; $display("FAIL lock_dout got %b/%b/%0d/%b want 1/1/1/0", dout, out_valid, adv_cnt, wrap);
    end
    tick();
    checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL lock_din_pulse got %b want 0", lockup); end
    // load and shift_en together: load wins.
    load = 1; shift_en = 1; seed_in = 16'h0001;
    tick();
    load = 0; shift_en = 0;
    checks++; if (state !== 16'h0001 || out_valid !== 1'b0 || adv_cnt !== 32'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_prio got %h/%b/%0d/%b want 0001/0/0/0", state, out_valid, adv_cnt, wrap);
    end
  endtask

  task automatic test_builds();
    logic [15:0] m4s, mls, ns;
    logic [3:0]  m4d;
    logic        m4v, mlv, mld, m4l, mll, m4w, mlw, a4, al;
    int          m4c, mlc;
    logic [16:0] r;
    rst = 1; #2 rst = 0;
    m4s = 16'hACE1; m4d = 0; m4v = 0; m4c = 0;
    mls = 16'hACE1; mld = 0; mlv = 0; mlc = 0;
    tick();
    for (int c = 0; c < 1000; c++) begin
      s4_en = ($urandom_range(0, 3) != 0); s4_din = 4'($urandom); s4_rdy = ($urandom_range(0, 3) != 0);
      lb_en = ($urandom_range(0, 3) != 0); lb_din = 1'($urandom); lb_rdy = ($urandom_range(0, 3) != 0);
      a4 = s4_en && (!m4v || s4_rdy); m4l = 0; m4w = 0;
      if (a4) begin
        ns = m4s;
        for (int j = 0; j < 4; j++) begin
          r = sub_step(ns, s4_din[j], 0, 16'h6801); m4d[j] = r[16]; ns = r[15:0];
        end
        m4l = (ns == 16'h0); if (m4l) ns = 16'hACE1;
        m4w = (ns == 16'hACE1); m4s = ns; m4v = 1; if (m4c < 15) m4c++;
      end else if (m4v && s4_rdy) m4v = 0;
      al = lb_en && (!mlv || lb_rdy); mll = 0; mlw = 0;
      if (al) begin
        r = sub_step(mls, lb_din, 1, 16'hB400); mld = r[16]; ns = r[15:0];
        mll = (ns == 16'h0); if (mll) ns = 16'hACE1;
        mlw = (ns == 16'hACE1); mls = ns; mlv = 1; mlc++;
      end else if (mlv && lb_rdy) mlv = 0;
      tick();
      checks++; if (s4_state !== m4s || s4_dout !== m4d) begin
        errors++; $display("FAIL s4_data[%0d] got %h/%h want %h/%h", c, s4_state, s4_dout, m4s, m4d);
      end
      checks++; if (s4_vld !== m4v || s4_cnt !== 4'(m4c) || s4_lock !== m4l || s4_wrap !== m4w) begin
        errors++; $display("FAIL s4_ctl[%0d] got %b/%0d/%b/%b want %b/%0d/%b/%b", c, s4_vld, s4_cnt, s4_lock, s4_wrap, m4v, m4c, m4l, m4w);
      end
      checks++; if (lb_state !== mls || lb_dout !== mld) begin
        errors++; $display("FAIL lsb_data[%0d] got %h/%b want %h/%b", c, lb_state, lb_dout, mls, mld);
      end
      checks++; if (lb_vld !== mlv || lb_cnt !== 32'(mlc) || lb_lock !== mll || lb_wrap !== mlw) begin
        errors++; $display("FAIL lsb_ctl[%0d] got %b/%0d/%b/%b want %b/%0d/%b/%b", c, lb_vld, lb_cnt, lb_lock, lb_wrap, mlv, mlc, mll, mlw);
      end
    end
    s4_en = 0; lb_en = 0;
  endtask

  initial begin
    s4_load = 0; s4_seed = 0; s4_en = 0; s4_din = 0; s4_rdy = 0;
    lb_load = 0; lb_seed = 0; lb_en = 0; lb_din = 0; lb_rdy = 0;
    test_reset();
    test_sequence();
    test_period();
    test_backpressure();
    test_lockup();
    test_builds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
